// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM subsystem (arbiter and controller):
//   - arb_state_t : arbiter scheduling states
//   - grant_t     : which requester owns the current burst
//   - address field helpers for the {bank, row, col} word address layout
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } grant_t;

  // Word address layout: {bank[22:21], row[20:9], col[8:0]}
  localparam int BANK_MSB = 22;
  localparam int BANK_LSB = 21;
  localparam int ROW_MSB  = 20;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

  function automatic logic [1:0] addr_bank(input logic [22:0] addr);
    return addr[BANK_MSB:BANK_LSB];
  endfunction

  function automatic logic [11:0] addr_row(input logic [22:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

  function automatic logic [8:0] addr_col(input logic [22:0] addr);
    return addr[COL_MSB:COL_LSB];
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// -----------------------------------------------------------------------------
// sdram_arb_if
// Request/acknowledge bundle between the burst arbiter and the SDRAM controller.
//   wr_req, rd_req : level requests (exactly one high while a request is pending)
//   wr_cnt         : burst length in words
//   wr_addr        : burst start word address
//   ctrl_idle      : controller sits in its idle state
//   ctrl_ack       : one-cycle pulse when the controller accepts a request
// Modports: master = arbiter side, slave = controller side.
// -----------------------------------------------------------------------------
interface sdram_arb_if #(
  parameter int ADDR_WIDTH = 23
);
  logic                  wr_req;
  logic                  rd_req;
  logic [8:0]            wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  ctrl_idle;
  logic                  ctrl_ack;

  modport master (
    output wr_req, rd_req, wr_cnt, wr_addr,
    input  ctrl_idle, ctrl_ack
  );

  modport slave (
    input  wr_req, rd_req, wr_cnt, wr_addr,
    output ctrl_idle, ctrl_ack
  );
endinterface

// File: rtl/sdram_arb_ptr.sv
// -----------------------------------------------------------------------------
// sdram_arb_ptr
// Wrapping burst pointer. Starts at BASE; each advance adds STEP. When the
// next start would lie beyond TOP the pointer reloads BASE instead and wrap
// pulses for one cycle, so a partial tail at the top of the region is skipped.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   advance   : step the pointer this cycle
//   ptr       : current burst start address
//   wrap      : one-cycle pulse after the pointer reloaded BASE
// -----------------------------------------------------------------------------
module sdram_arb_ptr #(
  parameter int                    ADDR_WIDTH = 23,
  parameter int                    STEP       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter logic [ADDR_WIDTH-1:0] TOP        = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  wrap
);

  // One extra bit so ptr + STEP can never overflow before the compare.
  localparam logic [ADDR_WIDTH:0] STEP_X = (ADDR_WIDTH+1)'(STEP);

  logic [ADDR_WIDTH:0] next_ptr;

  assign next_ptr = {1'b0, ptr} + STEP_X;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= BASE;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (advance) begin
        if (next_ptr > {1'b0, TOP}) begin
          ptr  <= BASE;
          wrap <= 1'b1;
        end else begin
          ptr <= next_ptr[ADDR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// -----------------------------------------------------------------------------
// sdram_arb
// Burst scheduler in front of the SDRAM controller. Shares the controller
// between the write-side source FIFO and the read-side sink FIFO, round-robin
// when both can move a full burst. Each request is held until the controller
// acknowledges it, then the arbiter waits for the controller to return idle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : allow new grants (an ongoing burst always completes)
//   wr_fifo_level   : words waiting in the write-side FIFO
//   rd_fifo_space   : free words in the read-side FIFO
//   ctl             : controller request/ack bundle (master side)
//   wr_busy/rd_busy : a write/read burst is granted and in progress
//   wr_done/rd_done : one-cycle pulse when a burst finishes
//   wr_wrap/rd_wrap : one-cycle pulse when a pointer reloads its base
//   ack_err         : sticky, controller never acknowledged a request
// -----------------------------------------------------------------------------
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 48,
  parameter int                    ADDR_WIDTH  = 23,
  parameter int                    BURST_LEN   = 256,
  parameter int                    LVL_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] WR_BASE     = '0,
  parameter logic [ADDR_WIDTH-1:0] WR_TOP      = 23'h03FFFF,
  parameter logic [ADDR_WIDTH-1:0] RD_BASE     = '0,
  parameter logic [ADDR_WIDTH-1:0] RD_TOP      = 23'h03FFFF,
  parameter int                    ACK_TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LVL_WIDTH-1:0] wr_fifo_level,
  input  logic [LVL_WIDTH-1:0] rd_fifo_space,
  sdram_arb_if.master          ctl,
  output logic                 wr_busy,
  output logic                 rd_busy,
  output logic                 wr_done,
  output logic                 rd_done,
  output logic                 wr_wrap,
  output logic                 rd_wrap,
  output logic                 ack_err
);

  if (DATA_WIDTH < 1 || BURST_LEN < 1 || BURST_LEN > 511 || ACK_TIMEOUT < 1) begin : g_param_check
    $error("sdram_arb: illegal parameter set");
  end

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  arb_state_t            state;
  grant_t                grant;
  grant_t                last_grant;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  run_armed;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  pick_wr;
  logic                  wr_adv;
  logic                  rd_adv;

  assign wr_elig = enable && (32'(wr_fifo_level) >= BURST_LEN);
  assign rd_elig = enable && (32'(rd_fifo_space) >= BURST_LEN);
  // Write wins when it is the only candidate or when read had the last turn.
  assign pick_wr = wr_elig && (!rd_elig || last_grant == READ);

  assign ctl.wr_cnt = 9'(BURST_LEN);

  // Pointers step during the single DONE cycle of their own burst.
  assign wr_adv = (state == DONE) && (grant == WRITE);
  assign rd_adv = (state == DONE) && (grant == READ);

  sdram_arb_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (BURST_LEN),
    .BASE       (WR_BASE),
    .TOP        (WR_TOP)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (wr_adv),
    .ptr     (wr_ptr),
    .wrap    (wr_wrap)
  );

  sdram_arb_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP       (BURST_LEN),
    .BASE       (RD_BASE),
    .TOP        (RD_TOP)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (rd_adv),
    .ptr     (rd_ptr),
    .wrap    (rd_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= WRITE;
      last_grant  <= READ;
      tmo_cnt     <= '0;
      run_armed   <= 1'b0;
      ctl.wr_req  <= 1'b0;
      ctl.rd_req  <= 1'b0;
      ctl.wr_addr <= '0;
      wr_busy     <= 1'b0;
      rd_busy     <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_elig || rd_elig) begin
            state   <= REQ;
            tmo_cnt <= '0;
            if (pick_wr) begin
              grant       <= WRITE;
              ctl.wr_req  <= 1'b1;
              wr_busy     <= 1'b1;
              ctl.wr_addr <= wr_ptr;
            end else begin
              grant       <= READ;
              ctl.rd_req  <= 1'b1;
              rd_busy     <= 1'b1;
              ctl.wr_addr <= rd_ptr;
            end
          end
        end
        // Request stays level: the controller may run a refresh before it
        // accepts, and ack may coincide with ctrl_idle still high.
        REQ: begin
          if (ctl.ctrl_ack) begin
            ctl.wr_req <= 1'b0;
            ctl.rd_req <= 1'b0;
            run_armed  <= 1'b0;
            state      <= RUN;
          end else if (tmo_cnt == TMO_LAST) begin
            ack_err    <= 1'b1;
            ctl.wr_req <= 1'b0;
            ctl.rd_req <= 1'b0;
            wr_busy    <= 1'b0;
            rd_busy    <= 1'b0;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        // First RUN cycle is masked so a stale ctrl_idle from the ack cycle
        // cannot end the burst before the controller has left idle.
        RUN: begin
          if (!run_armed) begin
            run_armed <= 1'b1;
          end else if (ctl.ctrl_idle) begin
            state      <= DONE;
            wr_done    <= (grant == WRITE);
            rd_done    <= (grant == READ);
            wr_busy    <= 1'b0;
            rd_busy    <= 1'b0;
            last_grant <= grant;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// -----------------------------------------------------------------------------
// tb_sdram_arb
// Directed bench for sdram_arb with BURST_LEN=4, write region 0..11, read
// region 0x100..0x10B and ACK_TIMEOUT=15. A small behavioural controller
// answers requests with a configurable refresh delay, ack delay and busy time.
// -----------------------------------------------------------------------------
module tb_sdram_arb;

  localparam int AW = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [9:0] wr_fifo_level = '0;
  logic [9:0] rd_fifo_space = '0;
  logic       wr_busy, rd_busy, wr_done, rd_done, wr_wrap, rd_wrap, ack_err;

  sdram_arb_if #(.ADDR_WIDTH(AW)) bus ();

  sdram_arb #(
    .DATA_WIDTH  (48),
    .ADDR_WIDTH  (AW),
    .BURST_LEN   (4),
    .LVL_WIDTH   (10),
    .WR_BASE     (23'h000000),
    .WR_TOP      (23'h00000B),
    .RD_BASE     (23'h000100),
    .RD_TOP      (23'h00010B),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .wr_fifo_level (wr_fifo_level),
    .rd_fifo_space (rd_fifo_space),
    .ctl           (bus),
    .wr_busy       (wr_busy),
    .rd_busy       (rd_busy),
    .wr_done       (wr_done),
    .rd_done       (rd_done),
    .wr_wrap       (wr_wrap),
    .rd_wrap       (rd_wrap),
    .ack_err       (ack_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Controller model configuration
  int m_ack_delay = 3;
  int m_refresh   = 0;
  int m_noack     = 0;
  int m_busy      = 10;
  int n_wr_ack    = 0;
  int n_rd_ack    = 0;

  // Monitor counters
  int n_both = 0, n_bad_cnt = 0, n_wr_req_cyc = 0, n_rd_req_cyc = 0;
  int n_wr_done = 0, n_wr_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural controller: inputs driven at negedge
  typedef enum int {M_IDLE, M_WAIT, M_ACK, M_BUSY} mstate_t;
  initial begin
    mstate_t ms;
    int rcnt, wcnt, bcnt;
    bit ack_wr;
    ms = M_IDLE; rcnt = 0; wcnt = 0; bcnt = 0; ack_wr = 1'b0;
    bus.ctrl_idle = 1'b1;
    bus.ctrl_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ms = M_IDLE; bus.ctrl_idle = 1'b1; bus.ctrl_ack = 1'b0;
        n_wr_ack = 0; n_rd_ack = 0;
      end else begin
        case (ms)
          M_IDLE: begin
            bus.ctrl_ack = 1'b0; bus.ctrl_idle = 1'b1;
            if (m_noack == 0 && (bus.wr_req || bus.rd_req)) begin
              ms = M_WAIT; rcnt = m_refresh; wcnt = m_ack_delay; ack_wr = bus.wr_req;
            end
          end
          M_WAIT: begin
            if (rcnt > 0) begin
              bus.ctrl_idle = 1'b0; rcnt--;
            end else if (wcnt > 1) begin
              bus.ctrl_idle = 1'b1; wcnt--;
            end else begin
              bus.ctrl_idle = 1'b1; bus.ctrl_ack = 1'b1; ms = M_ACK;
              if (ack_wr) n_wr_ack++; else n_rd_ack++;
            end
          end
          M_ACK: begin
            bus.ctrl_ack = 1'b0; bus.ctrl_idle = 1'b0; bcnt = m_busy; ms = M_BUSY;
          end
          default: begin
            if (bcnt > 1) bcnt--;
            else begin bus.ctrl_idle = 1'b1; ms = M_IDLE; end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n_both <= 0; n_bad_cnt <= 0; n_wr_req_cyc <= 0; n_rd_req_cyc <= 0;
      n_wr_done <= 0; n_wr_wrap <= 0;
    end else begin
      if (bus.wr_req && bus.rd_req) n_both <= n_both + 1;
      if (bus.wr_cnt != 9'd4)       n_bad_cnt <= n_bad_cnt + 1;
      if (bus.wr_req)               n_wr_req_cyc <= n_wr_req_cyc + 1;
      if (bus.rd_req)               n_rd_req_cyc <= n_rd_req_cyc + 1;
      if (wr_done)                  n_wr_done <= n_wr_done + 1;
      if (wr_wrap)                  n_wr_wrap <= n_wr_wrap + 1;
    end
  end

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.wr_req || bus.rd_req) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic count_req_high(output int n);
    n = 0;
    while ((bus.wr_req || bus.rd_req) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok, output bit dw);
    ok = 1'b0; dw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_done || rd_done) begin ok = 1'b1; dw = wr_done; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag, input bit en, input int wl, input int rs,
                          input int ad, input int rf, input int na);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, "_flags"}, 32'({bus.wr_req, bus.rd_req, wr_busy, rd_busy, wr_done, rd_done,
                              wr_wrap, rd_wrap, ack_err}), 32'd0);
    chk({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
    enable = en; wr_fifo_level = 10'(wl); rd_fifo_space = 10'(rs);
    m_ack_delay = ad; m_refresh = rf; m_noack = na;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_burst(input bit exp_wr, input logic [AW-1:0] exp_addr,
                              input int exp_req_cyc, input string tag);
    bit found, ok, dw;
    int n;
    wait_req(found);
    chk({tag, "_req_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_req_dir"}, 32'({bus.wr_req, bus.rd_req}), exp_wr ? 32'd2 : 32'd1);
      chk({tag, "_busy"}, 32'({wr_busy, rd_busy}), exp_wr ? 32'd2 : 32'd1);
      chk({tag, "_addr"}, 32'(bus.wr_addr), 32'(exp_addr));
      count_req_high(n);
      chk({tag, "_req_cycles"}, 32'(n), 32'(exp_req_cyc));
      wait_done(ok, dw);
      chk({tag, "_done_seen"}, 32'(ok), 32'd1);
      chk({tag, "_done_dir"}, 32'(dw), 32'(exp_wr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, ok, dw;
    int n, snap;

    // Reset state
    do_reset("rst0", 1'b1, 8, 0, 3, 0, 0);
    chk("wr_cnt_const", 32'(bus.wr_cnt), 32'd4);

    // Write only: addresses 0, 4, 8, then wrap to 0
    expect_burst(1'b1, 23'd0, 4, "w0");
    expect_burst(1'b1, 23'd4, 4, "w4");
    #1 chk("w_no_wrap_yet", 32'(n_wr_wrap), 32'd0);
    expect_burst(1'b1, 23'd8, 4, "w8");
    expect_burst(1'b1, 23'd0, 4, "w0_again");
    #1;
    chk("w_wrap_count", 32'(n_wr_wrap), 32'd1);
    chk("w_done_count", 32'(n_wr_done), 32'd4);
    chk("w_no_rd_req", 32'(n_rd_req_cyc), 32'd0);

    // Both eligible: round-robin starting with write
    do_reset("rst_rr", 1'b1, 8, 8, 3, 0, 0);
    expect_burst(1'b1, 23'h000, 4, "rr_w0");
    expect_burst(1'b0, 23'h100, 4, "rr_r0");
    expect_burst(1'b1, 23'h004, 4, "rr_w1");
    expect_burst(1'b0, 23'h104, 4, "rr_r1");
    #1;
    chk("rr_onehot_req", 32'(n_both), 32'd0);
    chk("rr_wr_cnt", 32'(n_bad_cnt), 32'd0);

    // Refresh before ack: request held level through refresh
    do_reset("rst_rfsh", 1'b1, 8, 0, 1, 7, 0);
    expect_burst(1'b1, 23'd0, 9, "rfsh");
    enable = 1'b0;
    #1;
    chk("rfsh_one_ack", 32'(n_wr_ack), 32'd1);
    chk("rfsh_one_done", 32'(n_wr_done), 32'd1);

    // No ack: timeout after 15 REQ cycles
    do_reset("rst_tmo", 1'b1, 8, 0, 3, 0, 1);
    wait_req(found);
    chk("tmo_req_seen", 32'(found), 32'd1);
    chk("tmo_addr", 32'(bus.wr_addr), 32'd0);
    count_req_high(n);
    chk("tmo_req_cycles", 32'(n), 32'd15);
    chk("tmo_ack_err", 32'(ack_err), 32'd1);
    chk("tmo_busy_clr", 32'(wr_busy), 32'd0);
    wait_req(found);
    chk("tmo_regrant", 32'(found), 32'd1);
    chk("tmo_ptr_kept", 32'(bus.wr_addr), 32'd0);
    chk("tmo_err_sticky", 32'(ack_err), 32'd1);

    // enable dropped during RUN
    do_reset("rst_en", 1'b1, 8, 0, 3, 0, 0);
    wait_req(found);
    chk("en_req_seen", 32'(found), 32'd1);
    count_req_high(n);
    chk("en_req_cycles", 32'(n), 32'd4);
    enable = 1'b0;
    wait_done(ok, dw);
    chk("en_done_seen", 32'(ok), 32'd1);
    chk("en_done_dir", 32'(dw), 32'd1);
    #1 snap = n_wr_req_cyc + n_rd_req_cyc;
    repeat (30) @(negedge clk);
    #1;
    chk("en_no_req_while_off", 32'(n_wr_req_cyc + n_rd_req_cyc - snap), 32'd0);
    chk("en_idle_busy", 32'(wr_busy), 32'd0);
    enable = 1'b1;
    expect_burst(1'b1, 23'd4, 4, "en_resume");

    // Reset during RUN
    wait_req(found);
    chk("rr2_req_seen", 32'(found), 32'd1);
    chk("rr2_addr", 32'(bus.wr_addr), 32'd8);
    count_req_high(n);
    chk("rr2_busy_in_run", 32'(wr_busy), 32'd1);
    do_reset("rst_run", 1'b1, 8, 0, 3, 0, 0);
    expect_burst(1'b1, 23'd0, 4, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Scheduler placed in front of the SDRAM controller (`sdram_c`). It shares the single controller between one write-side requester (capture FIFO) and one read-side requester (display FIFO).
- Decides which burst runs next and drives the controller's `wr_req`/`rd_req`/`wr_cnt`/`wr_addr` inputs.
- Holds each request until the controller accepts it, then waits for the burst to finish.
- Maintains independent write and read address pointers, each wrapping inside its own region of the SDRAM.

Parameters:
- DATA_WIDTH, 48, controller data width (informational; used only for level ports' consistency).
- ADDR_WIDTH, 23, controller address width {bank[22:21], row[20:9], col[8:0]}.
- BURST_LEN, 256, words per burst; range 1..511; drives wr_cnt.
- LVL_WIDTH, 10, width of FIFO level inputs.
- WR_BASE, 23'h000000, first word address of the write region.
- WR_TOP, 23'h03FFFF, last word address of the write region (inclusive).
- RD_BASE, 23'h000000, first word address of the read region.
- RD_TOP, 23'h03FFFF, last word address of the read region (inclusive).
- ACK_TIMEOUT, 4095, maximum cycles to wait for ctrl_ack before flagging an error.

Ports:
- clk, in, 1, system clock (same as controller).
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, 1 = scheduling allowed; 0 = finish current burst then stay idle.
- wr_fifo_level, in, LVL_WIDTH, words available in the write-side source FIFO.
- rd_fifo_space, in, LVL_WIDTH, free words in the read-side sink FIFO.
- ctrl_idle, in, 1, controller is in its idle state.
- ctrl_ack, in, 1, one-cycle pulse when the controller leaves idle to activate for a request (not for refresh).
- wr_req, out, 1, write request to controller.
- rd_req, out, 1, read request to controller.
- wr_cnt, out, 9, burst length to controller.
- wr_addr, out, ADDR_WIDTH, burst start address to controller.
- wr_busy, out, 1, a write burst is granted and in progress.
- rd_busy, out, 1, a read burst is granted and in progress.
- wr_done, out, 1, one-cycle pulse at the end of a write burst.
- rd_done, out, 1, one-cycle pulse at the end of a read burst.
- wr_wrap, out, 1, one-cycle pulse when the write pointer wraps to WR_BASE.
- rd_wrap, out, 1, one-cycle pulse when the read pointer wraps to RD_BASE.
- ack_err, out, 1, sticky flag: ACK_TIMEOUT expired; cleared only by rst.

Behaviour:
- Reset values:
  - State IDLE.
  - wr_req=rd_req=0; wr_busy=rd_busy=0; all pulses 0; ack_err=0.
  - wr_ptr=WR_BASE, rd_ptr=RD_BASE.
  - last_grant=READ, so WRITE wins the first tie.
- Eligibility:
  - wr_elig = enable && wr_fifo_level >= BURST_LEN.
  - rd_elig = enable && rd_fifo_space >= BURST_LEN.
- wr_cnt is constant BURST_LEN[8:0].
- wr_addr is registered. It loads wr_ptr or rd_ptr on entry to REQ and holds until the next REQ.
- State machine, one registered state:
  - IDLE: if both eligible, grant the opposite of last_grant (round-robin); otherwise grant whichever is eligible. Move to REQ next cycle and set the matching busy. Neither eligible: stay.
  - REQ: hold wr_req or rd_req high (exactly one) until ctrl_ack is sampled high. Deassert the request the cycle after ack, then go to RUN.
    - The request is held level, not pulsed, because the controller may enter refresh first.
    - ctrl_ack together with ctrl_idle high in the same cycle is still treated as accepted.
  - RUN: wait for ctrl_idle=1 sampled at least 2 cycles after ack (mask the ack cycle itself). Then go to DONE.
  - DONE, one cycle:
    - Pulse wr_done or rd_done.
    - Clear busy and update last_grant.
    - Advance the granted pointer by BURST_LEN. If ptr + BURST_LEN > TOP, load BASE instead and pulse the matching wrap.
    - Return to IDLE. Earliest re-grant is the following cycle.
- Pointer arithmetic: ADDR_WIDTH+1 bits, so the comparison never overflows. The region size need not be a multiple of BURST_LEN: a partial tail is skipped.
- Timeout: a counter runs in REQ. If it reaches ACK_TIMEOUT without ctrl_ack, set ack_err, drop the request, clear busy and return to IDLE. The pointer does not advance and last_grant does not change.
- enable falling mid-burst has no effect on REQ/RUN/DONE. It only blocks new grants in IDLE.
- FIFO level changes after a grant are ignored until the next IDLE evaluation.
- Reset mid-burst returns everything to reset values immediately (async). The controller is reset by the same reset tree.

Decomposition:
- Shared package `sdram_pkg`: the arbiter state encoding (IDLE/REQ/RUN/DONE), the grant enum (WRITE/READ), and the address field slices (bank/row/col) also used by `sdram_c`.
- One natural sub-module, `sdram_arb_ptr`: a wrapping burst pointer (base, top, step, advance → ptr, wrap pulse), instantiated twice.

Test Plan:
- Write only, BURST_LEN=4, WR_BASE=0, WR_TOP=11, wr_fifo_level=8 held, ctrl model acks 3 cycles after wr_req, stays busy 10 cycles → wr_addr sequence 0, 4, 8, 0; wr_wrap pulses after the third burst; rd_req never high.
- Both eligible continuously → grants alternate W, R, W, R starting with W; exactly one req high at any time; wr_cnt=4 always.
- Controller model does a 7-cycle refresh before acking → wr_req stays high through the refresh and drops the cycle after ack; one burst is counted, not two.
- No ack, ACK_TIMEOUT=15 → ack_err set at cycle 15 of REQ; request drops; wr_ptr unchanged; ack_err stays set until rst.
- enable deasserted during RUN → the burst completes with a wr_done pulse; no further wr_req/rd_req while enable=0; resumes on re-enable.
- rst asserted during RUN → all outputs 0 and pointers at base asynchronously; after release the first grant goes to WRITE at WR_BASE.
